// File: rtl/imem_fetch_ctrl_if.sv
// Instruction-fetch controller bus: loader stream, instruction-memory write
// and read ports, hazard/branch inputs and the IF/ID register outputs.
interface imem_fetch_ctrl_if #(
  parameter int ADDR_W = 12,
  parameter int INST_W = 16
);
  // Loader stream
  logic              ld_valid;
  logic              ld_ready;
  logic [INST_W-1:0] ld_data;
  logic              ld_last;
  // Instruction-memory write port
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [INST_W-1:0] imem_wdata;
  // Instruction-memory read port
  logic [ADDR_W-1:0] PCAdd_pc;
  logic [INST_W-1:0] M_instruction;
  // Pipeline control
  logic              stall;
  logic              br_taken;
  logic [ADDR_W-1:0] br_target;
  // IF/ID boundary and status
  logic [INST_W-1:0] IF_ID_inst;
  logic [ADDR_W-1:0] IF_ID_pc;
  logic              run;
  logic              halted;

  // Controller side
  modport master (
    input  ld_valid, ld_data, ld_last, M_instruction, stall, br_taken, br_target,
    output ld_ready, imem_we, imem_waddr, imem_wdata, PCAdd_pc,
           IF_ID_inst, IF_ID_pc, run, halted
  );

  // Environment side (loader, memory, hazard unit, pipeline)
  modport slave (
    output ld_valid, ld_data, ld_last, M_instruction, stall, br_taken, br_target,
    input  ld_ready, imem_we, imem_waddr, imem_wdata, PCAdd_pc,
           IF_ID_inst, IF_ID_pc, run, halted
  );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch controller: streams a boot program into instruction
// memory, then sequences the PC with stall, branch redirect and halt handling.
module imem_fetch_ctrl #(
  parameter int                ADDR_W   = 12,
  parameter int                INST_W   = 16,
  parameter logic [INST_W-1:0] NOP_INST = 16'h6000,
  parameter logic [3:0]        HALT_OP  = 4'hF
) (
  input logic               clk,
  input logic               reset,
  imem_fetch_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] if_pc_q;
  logic [INST_W-1:0] if_inst_q;
  logic              run_q;
  logic              halted_q;

  logic ld_ready_d;
  logic ld_accept_d;
  logic is_halt_d;

  // The loader is only accepted while loading and never while reset is asserted.
  assign ld_ready_d  = (state_q == S_LOAD) && !reset;
  assign ld_accept_d = ld_ready_d && bus.ld_valid;
  assign is_halt_d   = (bus.M_instruction[INST_W-1 -: 4] == HALT_OP);

  assign bus.ld_ready   = ld_ready_d;
  assign bus.imem_we    = ld_accept_d;
  assign bus.imem_waddr = cnt_q;
  assign bus.imem_wdata = bus.ld_data;
  assign bus.PCAdd_pc   = pc_q;
  assign bus.IF_ID_inst = if_inst_q;
  assign bus.IF_ID_pc   = if_pc_q;
  assign bus.run        = run_q;
  assign bus.halted     = halted_q;

  // Fetch FSM with registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_LOAD;
      pc_q      <= '0;
      cnt_q     <= '0;
      if_inst_q <= NOP_INST;
      if_pc_q   <= '0;
      run_q     <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      case (state_q)
        S_LOAD: begin
          pc_q      <= '0;
          if_inst_q <= NOP_INST;
          if (ld_accept_d) begin
            // Counter saturates at the top address so word 0 is never rewritten.
            if (cnt_q != '1) cnt_q <= cnt_q + ADDR_W'(1);
            if (bus.ld_last || (cnt_q == '1)) begin
              state_q <= S_RUN;
              run_q   <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (bus.br_taken) begin
            pc_q      <= bus.br_target;
            if_inst_q <= NOP_INST;
          end else if (bus.stall) begin
            pc_q      <= pc_q;
          end else if (is_halt_d) begin
            if_inst_q <= NOP_INST;
            state_q   <= S_HALT;
            run_q     <= 1'b0;
            halted_q  <= 1'b1;
          end else begin
            if_inst_q <= bus.M_instruction;
            if_pc_q   <= pc_q;
            pc_q      <= pc_q + ADDR_W'(1);
          end
        end
        S_HALT: begin
          if_inst_q <= NOP_INST;
          // A branch still in flight when the halt word was fetched wins.
          if (bus.br_taken) begin
            pc_q     <= bus.br_target;
            state_q  <= S_RUN;
            run_q    <= 1'b1;
            halted_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= S_LOAD;
          run_q    <= 1'b0;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed testbench for imem_fetch_ctrl with a behavioural 4096x16 memory.
module tb_imem_fetch_ctrl;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  logic [15:0] mem [4096];
  logic [15:0] prog [8];

  imem_fetch_ctrl_if #(.ADDR_W(12), .INST_W(16)) bus ();

  imem_fetch_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory model: synchronous write, combinational read.
  always @(posedge clk) begin
    if (bus.imem_we) mem[bus.imem_waddr] <= bus.imem_wdata;
  end
  assign bus.M_instruction = mem[bus.PCAdd_pc];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.ld_valid = 1'b0;
    bus.ld_last = 1'b0;
    bus.stall = 1'b0;
    bus.br_taken = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  // Streams prog[0..n-1] with ld_last on the final word, optionally with idle gaps.
  task automatic load_prog(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        bus.ld_valid = 1'b0;
        #1;
        checks++;
        if (bus.imem_we !== 1'b0) begin
          errors++;
          $display("FAIL load_gap_we: got %0b expected 0", bus.imem_we);
        end
        tick();
      end
      bus.ld_valid = 1'b1;
      bus.ld_data = prog[i];
      bus.ld_last = (i == n - 1);
      #1;
      $display("load word addr=%0d data=%h", i, prog[i]);
      checks++;
      if (bus.imem_we !== 1'b1 || bus.imem_waddr !== 12'(i)) begin
        errors++;
        $display("FAIL load_write: got we=%0b addr=%0d expected we=1 addr=%0d",
                 bus.imem_we, bus.imem_waddr, i);
      end
      checks++;
      if (bus.run !== 1'b0) begin
        errors++;
        $display("FAIL load_run_early: got %0b expected 0", bus.run);
      end
      tick();
    end
    bus.ld_valid = 1'b0;
    bus.ld_last = 1'b0;
    checks++;
    if (bus.run !== 1'b1 || bus.ld_ready !== 1'b0) begin
      errors++;
      $display("FAIL load_to_run: got run=%0b ld_ready=%0b expected run=1 ld_ready=0",
               bus.run, bus.ld_ready);
    end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (mem[i] !== prog[i]) begin
        errors++;
        $display("FAIL load_mem[%0d]: got %h expected %h", i, mem[i], prog[i]);
      end
    end
  endtask

  task automatic test_reset();
    $display("test_reset");
    reset = 1'b1;
    bus.ld_valid = 1'b1;
    bus.ld_data = 16'h1234;
    bus.ld_last = 1'b0;
    bus.stall = 1'b0;
    bus.br_taken = 1'b0;
    bus.br_target = '0;
    tick();
    tick();
    checks++;
    if (bus.ld_ready !== 1'b0 || bus.imem_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_we: got ready=%0b we=%0b expected 0 0", bus.ld_ready, bus.imem_we);
    end
    checks++;
    if (bus.run !== 1'b0 || bus.halted !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: got run=%0b halted=%0b expected 0 0", bus.run, bus.halted);
    end
    checks++;
    if (bus.PCAdd_pc !== 12'd0 || bus.IF_ID_pc !== 12'd0 || bus.IF_ID_inst !== 16'h6000) begin
      errors++;
      $display("FAIL reset_regs: got pc=%0d ifpc=%0d inst=%h expected 0 0 6000",
               bus.PCAdd_pc, bus.IF_ID_pc, bus.IF_ID_inst);
    end
    reset = 1'b0;
    bus.ld_valid = 1'b0;
    #1;
    checks++;
    if (bus.ld_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %0b expected 1", bus.ld_ready);
    end
  endtask

  task automatic test_load_run();
    $display("test_load_run");
    do_reset();
    prog[0] = 16'h6141; prog[1] = 16'h6122; prog[2] = 16'h6213;
    prog[3] = 16'h6324; prog[4] = 16'h6415;
    load_prog(5, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (bus.IF_ID_inst !== prog[i] || bus.IF_ID_pc !== 12'(i) || bus.PCAdd_pc !== 12'(i + 1)) begin
        errors++;
        $display("FAIL fetch_seq[%0d]: got inst=%h ifpc=%0d pc=%0d expected %h %0d %0d",
                 i, bus.IF_ID_inst, bus.IF_ID_pc, bus.PCAdd_pc, prog[i], i, i + 1);
      end
    end
  endtask

  task automatic test_stall();
    $display("test_stall");
    do_reset();
    prog[0] = 16'h6141; prog[1] = 16'h6122; prog[2] = 16'h6213; prog[3] = 16'h6324;
    prog[4] = 16'h6415; prog[5] = 16'h6516; prog[6] = 16'h6617;
    load_prog(7, 1'b1);
    tick();
    tick();
    checks++;
    if (bus.PCAdd_pc !== 12'd2) begin
      errors++;
      $display("FAIL stall_setup_pc: got %0d expected 2", bus.PCAdd_pc);
    end
    bus.stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (bus.PCAdd_pc !== 12'd2 || bus.IF_ID_inst !== 16'h6122 || bus.IF_ID_pc !== 12'd1) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got pc=%0d inst=%h ifpc=%0d expected 2 6122 1",
                 k, bus.PCAdd_pc, bus.IF_ID_inst, bus.IF_ID_pc);
      end
    end
    bus.stall = 1'b0;
    tick();
    checks++;
    if (bus.IF_ID_inst !== 16'h6213 || bus.IF_ID_pc !== 12'd2 || bus.PCAdd_pc !== 12'd3) begin
      errors++;
      $display("FAIL stall_resume: got inst=%h ifpc=%0d pc=%0d expected 6213 2 3",
               bus.IF_ID_inst, bus.IF_ID_pc, bus.PCAdd_pc);
    end
  endtask

  // Continues from test_stall (pc = 3, program of 7 words loaded).
  task automatic test_branch();
    $display("test_branch");
    for (int pass = 0; pass < 2; pass++) begin
      while (bus.PCAdd_pc != 12'd6) tick();
      bus.br_taken = 1'b1;
      bus.br_target = 12'd1;
      bus.stall = (pass == 1);
      tick();
      checks++;
      if (bus.IF_ID_inst !== 16'h6000 || bus.PCAdd_pc !== 12'd1 || bus.IF_ID_pc !== 12'd5) begin
        errors++;
        $display("FAIL branch_flush[%0d]: got inst=%h pc=%0d ifpc=%0d expected 6000 1 5",
                 pass, bus.IF_ID_inst, bus.PCAdd_pc, bus.IF_ID_pc);
      end
      bus.br_taken = 1'b0;
      bus.stall = 1'b0;
      tick();
      checks++;
      if (bus.IF_ID_inst !== 16'h6122 || bus.IF_ID_pc !== 12'd1 || bus.PCAdd_pc !== 12'd2) begin
        errors++;
        $display("FAIL branch_target[%0d]: got inst=%h ifpc=%0d pc=%0d expected 6122 1 2",
                 pass, bus.IF_ID_inst, bus.IF_ID_pc, bus.PCAdd_pc);
      end
    end
  endtask

  task automatic test_halt();
    $display("test_halt");
    do_reset();
    prog[0] = 16'h6141; prog[1] = 16'h6122; prog[2] = 16'h6213;
    prog[3] = 16'h6324; prog[4] = 16'h6415; prog[5] = 16'hF000;
    load_prog(6, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (bus.halted !== 1'b0 || bus.PCAdd_pc !== 12'd5 || bus.IF_ID_inst !== 16'h6415) begin
      errors++;
      $display("FAIL halt_pre: got halted=%0b pc=%0d inst=%h expected 0 5 6415",
               bus.halted, bus.PCAdd_pc, bus.IF_ID_inst);
    end
    for (int k = 0; k < 4; k++) begin
      bus.stall = (k == 2);
      tick();
      checks++;
      if (bus.halted !== 1'b1 || bus.run !== 1'b0 || bus.PCAdd_pc !== 12'd5 ||
          bus.IF_ID_inst !== 16'h6000) begin
        errors++;
        $display("FAIL halt_hold[%0d]: got halted=%0b run=%0b pc=%0d inst=%h expected 1 0 5 6000",
                 k, bus.halted, bus.run, bus.PCAdd_pc, bus.IF_ID_inst);
      end
    end
    bus.br_taken = 1'b1;
    bus.br_target = 12'd0;
    bus.stall = 1'b1;
    tick();
    checks++;
    if (bus.run !== 1'b1 || bus.halted !== 1'b0 || bus.PCAdd_pc !== 12'd0 ||
        bus.IF_ID_inst !== 16'h6000) begin
      errors++;
      $display("FAIL halt_exit: got run=%0b halted=%0b pc=%0d inst=%h expected 1 0 0 6000",
               bus.run, bus.halted, bus.PCAdd_pc, bus.IF_ID_inst);
    end
    bus.br_taken = 1'b0;
    bus.stall = 1'b0;
    tick();
    checks++;
    if (bus.IF_ID_inst !== 16'h6141 || bus.IF_ID_pc !== 12'd0 || bus.PCAdd_pc !== 12'd1) begin
      errors++;
      $display("FAIL halt_restart: got inst=%h ifpc=%0d pc=%0d expected 6141 0 1",
               bus.IF_ID_inst, bus.IF_ID_pc, bus.PCAdd_pc);
    end
  endtask

  task automatic test_full_load();
    logic [11:0] a;
    $display("test_full_load");
    do_reset();
    for (int i = 0; i < 4096; i++) begin
      a = 12'(i);
      bus.ld_valid = 1'b1;
      bus.ld_last = 1'b0;
      bus.ld_data = {4'h7, a};
      #1;
      checks++;
      if (bus.imem_we !== 1'b1 || bus.imem_waddr !== a || bus.run !== 1'b0) begin
        errors++;
        $display("FAIL full_load_write[%0d]: got we=%0b addr=%0d run=%0b expected 1 %0d 0",
                 i, bus.imem_we, bus.imem_waddr, bus.run, i);
      end
      tick();
    end
    $display("full load done: 4096 words");
    checks++;
    if (bus.run !== 1'b1 || bus.imem_we !== 1'b0 || bus.ld_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_load_run: got run=%0b we=%0b ready=%0b expected 1 0 0",
               bus.run, bus.imem_we, bus.ld_ready);
    end
    checks++;
    if (mem[0] !== 16'h7000 || mem[4095] !== 16'h7FFF) begin
      errors++;
      $display("FAIL full_load_mem: got m0=%h m4095=%h expected 7000 7fff", mem[0], mem[4095]);
    end
    bus.ld_valid = 1'b0;
    bus.br_taken = 1'b1;
    bus.br_target = 12'd4094;
    tick();
    bus.br_taken = 1'b0;
    tick();
    checks++;
    if (bus.IF_ID_inst !== 16'h7FFE || bus.PCAdd_pc !== 12'd4095) begin
      errors++;
      $display("FAIL wrap_4094: got inst=%h pc=%0d expected 7ffe 4095", bus.IF_ID_inst, bus.PCAdd_pc);
    end
    tick();
    checks++;
    if (bus.IF_ID_inst !== 16'h7FFF || bus.IF_ID_pc !== 12'd4095 || bus.PCAdd_pc !== 12'd0) begin
      errors++;
      $display("FAIL wrap_4095: got inst=%h ifpc=%0d pc=%0d expected 7fff 4095 0",
               bus.IF_ID_inst, bus.IF_ID_pc, bus.PCAdd_pc);
    end
    tick();
    checks++;
    if (bus.IF_ID_inst !== 16'h7000 || bus.IF_ID_pc !== 12'd0 || bus.PCAdd_pc !== 12'd1) begin
      errors++;
      $display("FAIL wrap_0: got inst=%h ifpc=%0d pc=%0d expected 7000 0 1",
               bus.IF_ID_inst, bus.IF_ID_pc, bus.PCAdd_pc);
    end
  endtask

  task automatic test_reset_mid_run();
    $display("test_reset_mid_run");
    do_reset();
    prog[0] = 16'h6141; prog[1] = 16'h6122; prog[2] = 16'h6213;
    prog[3] = 16'h6324; prog[4] = 16'h6415;
    load_prog(5, 1'b0);
    tick();
    tick();
    tick();
    checks++;
    if (bus.PCAdd_pc !== 12'd3) begin
      errors++;
      $display("FAIL midrst_setup_pc: got %0d expected 3", bus.PCAdd_pc);
    end
    reset = 1'b1;
    bus.ld_valid = 1'b1;
    bus.ld_data = 16'h1234;
    #1;
    checks++;
    if (bus.ld_ready !== 1'b0 || bus.imem_we !== 1'b0) begin
      errors++;
      $display("FAIL midrst_ready: got ready=%0b we=%0b expected 0 0", bus.ld_ready, bus.imem_we);
    end
    tick();
    checks++;
    if (bus.run !== 1'b0 || bus.PCAdd_pc !== 12'd0 || bus.IF_ID_inst !== 16'h6000 ||
        bus.IF_ID_pc !== 12'd0) begin
      errors++;
      $display("FAIL midrst_state: got run=%0b pc=%0d inst=%h ifpc=%0d expected 0 0 6000 0",
               bus.run, bus.PCAdd_pc, bus.IF_ID_inst, bus.IF_ID_pc);
    end
    reset = 1'b0;
    bus.ld_valid = 1'b0;
    #1;
    checks++;
    if (bus.ld_ready !== 1'b1 || mem[0] !== 16'h6141) begin
      errors++;
      $display("FAIL midrst_after: got ready=%0b m0=%h expected 1 6141", bus.ld_ready, mem[0]);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 4096; i++) mem[i] = 16'h6000;
    reset = 1'b1;
    bus.ld_valid = 1'b0;
    bus.ld_data = '0;
    bus.ld_last = 1'b0;
    bus.stall = 1'b0;
    bus.br_taken = 1'b0;
    bus.br_target = '0;
    test_reset();
    test_load_run();
    test_stall();
    test_branch();
    test_halt();
    test_full_load();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
